// File: rtl/updown_sweep_ctrl.sv
// Triangular lo->hi->lo sweep sequencer driving a WIDTH-bit up/down count; registered outputs, start accepted only in IDLE.
// Optional turnaround dwell (HOLD state) is enabled by defining SWEEP_DWELL_EN.
module updown_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int CYC_W = 8,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] cycles,
    output logic [WIDTH-1:0] count,
    output logic             ud,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CYC_W-1:0] cyc_done
);

    if (DWELL < 1 || DWELL > 15) begin : g_dwell_range
        $error("updown_sweep_ctrl: DWELL must be in 1..15");
    end

`ifdef SWEEP_DWELL_EN
    typedef enum logic [2:0] {IDLE, UP, DOWN, HOLD, DONE} state_t;
    localparam logic [3:0] DWELL_LD = 4'(DWELL - 1);
    logic [3:0] dwell_cnt;
`else
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;
`endif

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [CYC_W-1:0] ONE_C = CYC_W'(1);

    state_t           state;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [CYC_W-1:0] cyc_q;
    logic [WIDTH-1:0] up_nxt;
    logic [WIDTH-1:0] dn_nxt;
    logic [CYC_W-1:0] cd_nxt;
    logic             running;

    assign up_nxt = count + ONE_W;
    assign dn_nxt = count - ONE_W;
    assign cd_nxt = cyc_done + ONE_C;

`ifdef SWEEP_DWELL_EN
    assign running = (state == UP) || (state == DOWN) || (state == HOLD);
`else
    assign running = (state == UP) || (state == DOWN);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            count    <= '0;
            ud       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cyc_done <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            cyc_q    <= '0;
`ifdef SWEEP_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // abort leaves count/ud/cyc_done visible so software can see where the run stopped
            if (abort && running) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (!pause || !running) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if ((lo < hi) && (cycles != '0)) begin
                                lo_q     <= lo;
                                hi_q     <= hi;
                                cyc_q    <= cycles;
                                count    <= lo;
                                ud       <= 1'b1;
                                busy     <= 1'b1;
                                cyc_done <= '0;
                                state    <= UP;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    UP: begin
                        count <= up_nxt;
                        if (up_nxt == hi_q) begin
                            ud <= 1'b0;
`ifdef SWEEP_DWELL_EN
                            dwell_cnt <= DWELL_LD;
                            state     <= HOLD;
`else
                            state <= DOWN;
`endif
                        end
                    end
                    DOWN: begin
                        count <= dn_nxt;
                        if (dn_nxt == lo_q) begin
                            cyc_done <= cd_nxt;
                            // final lo completes the run with no turnaround dwell
                            if (cd_nxt == cyc_q) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                ud <= 1'b1;
`ifdef SWEEP_DWELL_EN
                                dwell_cnt <= DWELL_LD;
                                state     <= HOLD;
`else
                                state <= UP;
`endif
                            end
                        end
                    end
`ifdef SWEEP_DWELL_EN
                    HOLD: begin
                        if (dwell_cnt == '0) begin
                            state <= ud ? UP : DOWN;
                        end else begin
                            dwell_cnt <= dwell_cnt - 4'd1;
                        end
                    end
`endif
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: a trajectory-list reference model predicts every cycle's outputs.
module tb_updown_sweep_ctrl;

    typedef struct packed {
        logic [3:0] cnt;
        logic       ud;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] cd;
    } exp_t;

`ifdef SWEEP_DWELL_EN
    localparam int DW = 2;
`else
    localparam int DW = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       pause;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] cycles;
    logic [3:0] count;
    logic       ud;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cyc_done;

    updown_sweep_ctrl #(.WIDTH(4), .CYC_W(8), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .lo(lo), .hi(hi), .cycles(cycles),
        .count(count), .ud(ud), .busy(busy), .done(done), .err(err), .cyc_done(cyc_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    // reference model: a run is the precomputed list of post-edge outputs
    exp_t traj[$];
    int   m_idx;
    bit   m_run;
    bit   m_fin;
    exp_t m_out;

    function automatic exp_t mk(input int c, input bit u, input bit b, input bit d, input int cd);
        exp_t e;
        e.cnt  = 4'(c);
        e.ud   = u;
        e.busy = b;
        e.done = d;
        e.err  = 1'b0;
        e.cd   = 8'(cd);
        return e;
    endfunction

    task automatic build_traj(input int l, input int h, input int c);
        traj.delete();
        traj.push_back(mk(l, 1, 1, 0, 0));
        for (int s = 1; s <= c; s++) begin
            for (int v = l + 1; v <= h; v++) traj.push_back(mk(v, v != h, 1, 0, s - 1));
            for (int d = 0; d < DW; d++) traj.push_back(mk(h, 0, 1, 0, s - 1));
            for (int v = h - 1; v > l; v--) traj.push_back(mk(v, 0, 1, 0, s - 1));
            if (s == c) begin
                traj.push_back(mk(l, 0, 0, 1, s));
            end else begin
                traj.push_back(mk(l, 1, 1, 0, s));
                for (int d = 0; d < DW; d++) traj.push_back(mk(l, 1, 1, 0, s));
            end
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic a, input logic p,
                              input logic [3:0] l, input logic [3:0] h, input logic [7:0] c);
        m_out.done = 1'b0;
        m_out.err  = 1'b0;
        if (!r) begin
            m_out    = '0;
            m_out.ud = 1'b1;
            m_run    = 0;
            m_fin    = 0;
        end else if (m_run) begin
            if (a) begin
                m_run      = 0;
                m_out.busy = 1'b0;
            end else if (!p) begin
                m_idx++;
                m_out = traj[m_idx];
                if (m_out.done) begin
                    m_run = 0;
                    m_fin = 1;
                end
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (s) begin
            if (l < h && c != 0) begin
                build_traj(int'(l), int'(h), int'(c));
                m_idx = 0;
                m_out = traj[0];
                m_run = 1;
            end else begin
                m_out.err = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic p,
                        input logic [3:0] l, input logic [3:0] h, input logic [7:0] c);
        @(negedge clk);
        rst = r; start = s; abort = a; pause = p; lo = l; hi = h; cycles = c;
        model_step(r, s, a, p, l, h, c);
        sb.push_back(m_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 4'd0, 4'd0, 8'd0);
    endtask

    // monitor: every edge produces an output word, compared 1 time unit after the edge
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {count, ud, busy, done, err, cyc_done};
                n_tests++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got cnt=%0d ud=%0b busy=%0b done=%0b err=%0b cyc_done=%0d, want cnt=%0d ud=%0b busy=%0b done=%0b err=%0b cyc_done=%0d",
                             $time, act.cnt, act.ud, act.busy, act.done, act.err, act.cd,
                             e.cnt, e.ud, e.busy, e.done, e.err, e.cd);
                end
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
        lo = '0; hi = '0; cycles = '0;
        m_run = 0; m_fin = 0; m_idx = 0; m_out = '0; m_out.ud = 1'b1;

        // reset
        step(0, 0, 0, 0, 4'd0, 4'd0, 8'd0);
        step(0, 0, 0, 0, 4'd0, 4'd0, 8'd0);
        idle(2);

        // normal run 2..5, two sweeps
        step(1, 1, 0, 0, 4'd2, 4'd5, 8'd2);
        idle(16);

        // rejected starts
        step(1, 1, 0, 0, 4'd7, 4'd7, 8'd1);
        idle(2);
        step(1, 1, 0, 0, 4'd1, 4'd4, 8'd0);
        idle(2);
        step(1, 1, 0, 0, 4'd9, 4'd3, 8'd2);
        idle(2);

        // pause at 6 going up, abort at 9 going down
        step(1, 1, 0, 0, 4'd0, 4'd15, 8'd1);
        guard = 0;
        while (!(m_out.cnt == 4'd6 && m_out.ud) && guard < 40) begin idle(1); guard++; end
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 4'd0, 4'd0, 8'd0);
        guard = 0;
        while (!(m_out.cnt == 4'd9 && !m_out.ud) && guard < 40) begin idle(1); guard++; end
        step(1, 0, 1, 0, 4'd0, 4'd0, 8'd0);
        idle(4);

        // full range, three sweeps, with ignored mid-run starts
        step(1, 1, 0, 0, 4'd0, 4'd15, 8'd3);
        for (int i = 0; i < 95; i++) begin
            if (i % 17 == 5) step(1, 1, 0, 0, 4'd3, 4'd9, 8'd1);
            else idle(1);
        end

        // short run exercising turnaround at both ends
        step(1, 1, 0, 0, 4'd1, 4'd3, 8'd1);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, s, a, p;
            logic [3:0] l, h;
            logic [7:0] c;
            r = ($urandom_range(0, 399) != 0);
            s = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 7) == 0);
            l = 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                            : 4'($urandom_range(int'(l), 15));
            c = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            step(r, s, a, p, l, h, c);
        end

        // final reset check, then drain
        step(0, 0, 0, 0, 4'd0, 4'd0, 8'd0);
        idle(1);
        @(posedge clk);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer for the 4-bit up/down counter datapath.
- Runs a programmed triangular sweep lo -> hi -> lo a given number of times, then reports completion.
- Owns the count register and the ud direction bit; the surrounding design sees a start/busy/done handshake.
- Sits between a control/config source (start, bounds, repeat count) and logic that consumes count and ud.

Parameters:
- WIDTH, 4, count and bound width in bits.
- CYC_W, 8, width of the repeat-count field and the completed-sweep counter.
- DWELL, 2, hold cycles at each turnaround (used only with SWEEP_DWELL_EN; legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  request a sweep; sampled only in IDLE.
- abort  input  1  cancel the current sweep.
- pause  input  1  freeze the sweep while high.
- lo  input  WIDTH  lower bound; latched on accepted start.
- hi  input  WIDTH  upper bound; latched on accepted start.
- cycles  input  CYC_W  number of full sweeps; latched on accepted start.
- count  output  WIDTH  current counter value (registered).
- ud  output  1  direction: 1 = up, 0 = down (registered).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse when a start is rejected.
- cyc_done  output  CYC_W  number of full sweeps completed in the current or last run.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, count=0, ud=1, busy=0, done=0, err=0, cyc_done=0, latched config=0.
- Priority: rst > abort > pause > normal operation.
- States: IDLE, UP, DOWN, DONE (+ HOLD with option). All outputs registered; done and err default to 0 each cycle.
- IDLE: count and ud hold.
  - On start==1 with lo<hi and cycles!=0: latch lo/hi/cycles; count<=lo, ud<=1, busy<=1, cyc_done<=0; go to UP.
  - On start==1 with lo>=hi or cycles==0: err<=1 for one cycle; stay IDLE; nothing latched.
- UP: count<=count+1. On the edge where count becomes hi: ud<=0, go to DOWN.
- DOWN: count<=count-1. On the edge where count becomes lo: cyc_done<=cyc_done+1.
  - If cyc_done+1==cycles: go to DONE, busy<=0, done<=1.
  - Otherwise: ud<=1, go to UP.
- DONE: lasts one cycle; done returns to 0; go to IDLE. count stays lo and ud stays 0 until the next start.
- Latency: count=lo on the edge that accepts start.
  - One sweep = 2*(hi-lo) edges; a run of N sweeps takes 2*N*(hi-lo) edges after acceptance.
  - done is high in the cycle immediately after the final count==lo edge.
- pause==1 in UP/DOWN/HOLD: count, ud, state, cyc_done and the dwell timer all hold. pause has no effect in IDLE/DONE.
- abort==1 in UP/DOWN/HOLD: go to IDLE, busy<=0, no done; count, ud and cyc_done hold their current values. abort in IDLE/DONE is ignored.
- start while not in IDLE is ignored; config does not change mid-run.
- Arithmetic never wraps because lo<hi is enforced. hi=2^WIDTH-1 and lo=0 are legal.
- cycles=1 gives a single up/down excursion.

Optional Feature:
- Macro SWEEP_DWELL_EN.
- Defined: when count reaches hi (in UP) or a non-final lo (in DOWN), enter HOLD for DWELL cycles with count frozen and ud already reversed, then resume in the opposite direction. The final lo goes straight to DONE with no dwell. Each sweep then takes 2*(hi-lo)+2*DWELL edges, except the final one, which has only one dwell.
- Undefined: no HOLD state and no dwell timer; the direction reverses immediately, as described above.

Test Plan:
- Reset: rst=0 for 2 cycles -> count=0, ud=1, busy=0, done=0, err=0, cyc_done=0.
- Normal run: lo=2, hi=5, cycles=2, 1-cycle start pulse -> count 2,3,4,5,4,3,2,3,4,5,4,3,2 on consecutive edges; busy high throughout; done pulses once the cycle after the final 2; cyc_done=2.
- Reject: start with lo=7, hi=7, and separately with cycles=0 -> err one-cycle pulse, busy stays 0, count unchanged.
- Pause and abort: lo=0, hi=15, cycles=1; pause for 3 cycles at count=6 -> count holds 6 for 3 cycles, then continues to 7. Abort at count=9 while going down -> busy=0 next cycle, no done, count holds 9.
- Boundary: lo=0, hi=15, cycles=3 -> count reaches 15 and 0 with no wrap to 0/15 glitch; start asserted mid-run is ignored; total of 90 edges to done.
- SWEEP_DWELL_EN with DWELL=2: lo=1, hi=3, cycles=1 -> count 1,2,3,3,3,2,1; done follows; no dwell at the final 1.
